ms_timer_sched: RTL and testbench



---
 rtl/ms_timer_sched_pkg.sv | 14 +
 rtl/ms_timer_sched_if.sv | 34 +++
 rtl/ms_timer_sched_rr_arb.sv | 40 ++++
 rtl/ms_timer_sched.sv | 84 ++++++++
 tb/tb_ms_timer_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ms_timer_sched_pkg.sv
// ms_timer_sched_pkg
// Constants shared by the millisecond timer scheduler and the board tick
// generator: default channel count, default period width and the clock
// rates that define the 1 ms strobe.
package ms_timer_sched_pkg;

  localparam int NCH_DEFAULT = 4;
  localparam int PW_DEFAULT  = 16;

  localparam int FCLK       = 50_000_000;
  localparam int F1KHZ      = 1000;
  localparam int CYC_PER_MS = FCLK / F1KHZ;

endpackage

// File: rtl/ms_timer_sched_if.sv
// ms_timer_sched_if
// Request/response bundle between the requesters and the timer bank.
//   start   : per-channel start request, held until granted
//   period  : per-channel interval in ms, slice i = period[i*PW +: PW]
//   cancel  : per-channel level abort
//   grant   : one-hot combinational acceptance of start
//   busy    : channel is counting
//   expired : one-cycle pulse when a channel's interval elapses
// master = requester side, slave = timer bank side.
interface ms_timer_sched_if
  import ms_timer_sched_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int PW  = PW_DEFAULT
) ();

  logic [NCH-1:0]    start;
  logic [NCH*PW-1:0] period;
  logic [NCH-1:0]    cancel;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    expired;

  modport master (
    output start, period, cancel,
    input  grant, busy, expired
  );

  modport slave (
    input  start, period, cancel,
    output grant, busy, expired
  );

endinterface

// File: rtl/ms_timer_sched_rr_arb.sv
// rr_arb
// Purely combinational NCH-wide round-robin arbiter. Grants the first
// requesting channel at or after ptr, scanning upward with wrap-around.
//   req : request vector
//   ptr : highest-priority channel this cycle (register lives in the caller)
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : binary index of the granted channel (0 when nothing requests)
module rr_arb #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);

  logic          found;
  logic [IW-1:0] cidx;
  int            c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      cidx = IW'(c);
      if (!found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/ms_timer_sched.sv
// ms_timer_sched
// Multi-channel one-shot millisecond timer bank. Start requests share one
// load port, so at most one channel is loaded per cycle, chosen round-robin.
// Every busy channel counts down on each 1 ms strobe and pulses expired for
// one cycle when its interval elapses.
//   clk, rst : system clock, synchronous active-high reset
//   ce1ms    : one-cycle 1 ms clock-enable strobe
//   bus      : start/period/cancel in, grant/busy/expired out (slave side)
module ms_timer_sched
  import ms_timer_sched_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int PW  = PW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce1ms,
  ms_timer_sched_if.slave  bus
);

  localparam int IW = $clog2(NCH);

  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  ptr;
  logic [PW-1:0]  cnt [NCH];
  logic [NCH-1:0] busy_r;
  logic [NCH-1:0] expired_r;

  // A cancelled channel never competes, so cancel also beats start.
  assign req = bus.start & ~bus.cancel;

  rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  // While rst is high no load happens, so the advertised grant is suppressed.
  assign bus.grant   = rst ? '0 : gnt;
  assign bus.busy    = busy_r;
  assign bus.expired = expired_r;

  // Per channel priority: cancel > load (grant) > decrement on ce1ms.
  // A period of zero expires on the cycle after the grant without ever
  // becoming busy; a grant on a busy channel silently replaces its count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      busy_r    <= '0;
      expired_r <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      if (|gnt) ptr <= (idx == IW'(NCH - 1)) ? '0 : idx + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        expired_r[i] <= 1'b0;
        if (bus.cancel[i]) begin
          busy_r[i] <= 1'b0;
          cnt[i]    <= '0;
        end else if (gnt[i]) begin
          if (bus.period[i*PW +: PW] != '0) begin
            cnt[i]    <= bus.period[i*PW +: PW];
            busy_r[i] <= 1'b1;
          end else begin
            cnt[i]       <= '0;
            busy_r[i]    <= 1'b0;
            expired_r[i] <= 1'b1;
          end
        end else if (ce1ms && busy_r[i] && (cnt[i] != '0)) begin
          if (cnt[i] == PW'(1)) begin
            cnt[i]       <= '0;
            busy_r[i]    <= 1'b0;
            expired_r[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_timer_sched.sv
// tb_ms_timer_sched
// Scoreboard bench for ms_timer_sched. The 1 ms strobe schedule is fixed up
// front, so every grant can be turned straight into a predicted expiry cycle
// (the cycle after the P-th strobe following the grant). The driver records
// these timer lifetimes and the expected grant of each cycle; a monitor on
// the falling edge compares grant, busy and expired against them.
module tb_ms_timer_sched;
  import ms_timer_sched_pkg::*;

  localparam int NCH  = 4;
  localparam int PW   = 16;
  localparam int NCYC = 3000;
  localparam int BIG  = 1 << 30;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ce1ms = 1'b0;

  ms_timer_sched_if #(.NCH(NCH), .PW(PW)) bus ();

  ms_timer_sched #(.NCH(NCH), .PW(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ce1ms (ce1ms),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One timer lifetime: granted in cycle tg, busy for tg < n < te,
  // expired pulse in cycle te when fires is set.
  typedef struct {
    int ch;
    int tg;
    int te;
    bit fires;
  } ent_t;

  ent_t           ent_q[$];
  logic [NCH-1:0] gexp_q[$];
  bit             ce_sched[NCYC];

  bit             req_pend[NCH];
  int             req_per[NCH];
  logic [NCH-1:0] cancel_now;
  bit             rst_now;
  int             ptr_m;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int exp_cycle(int t, int p);
    int k;
    k = 0;
    if (p == 0) return t + 1;
    for (int u = t + 1; u < NCYC; u++) begin
      if (ce_sched[u]) begin
        k++;
        if (k == p) return u + 1;
      end
    end
    return BIG;
  endfunction

  // End a channel's pending lifetime at cycle n without an expiry pulse.
  task automatic kill(int c, int n);
    foreach (ent_q[k]) begin
      if (ent_q[k].ch == c && ent_q[k].te > n) begin
        ent_q[k].fires = 1'b0;
        ent_q[k].te    = n + 1;
      end
    end
  endtask

  task automatic tick_cycle();
    int n;
    int c;
    logic [NCH-1:0] st;
    logic [NCH-1:0] g;
    @(posedge clk);
    #1;
    n     = cyc;
    rst   = rst_now;
    ce1ms = ce_sched[n];
    bus.cancel = cancel_now;
    for (int i = 0; i < NCH; i++) begin
      st[i] = req_pend[i];
      bus.period[i*PW +: PW] = PW'(req_per[i]);
    end
    bus.start = st;
    g = '0;
    for (int k = ent_q.size() - 1; k >= 0; k--)
      if (ent_q[k].te < n) ent_q.delete(k);
    if (rst_now) begin
      for (int i = 0; i < NCH; i++) kill(i, n);
      ptr_m = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (cancel_now[i]) kill(i, n);
      for (int k = 0; k < NCH; k++) begin
        c = (ptr_m + k) % NCH;
        if (st[c] && !cancel_now[c]) begin
          g[c] = 1'b1;
          kill(c, n);
          ent_q.push_back('{c, n, exp_cycle(n, req_per[c]), 1'b1});
          req_pend[c] = 1'b0;
          ptr_m = (c + 1) % NCH;
          break;
        end
      end
    end
    gexp_q.push_back(g);
  endtask

  task automatic at(int c);
    while (cyc + 1 < c) tick_cycle();
  endtask

  task automatic req(int ch, int p);
    req_pend[ch] = 1'b1;
    req_per[ch]  = p;
  endtask

  task automatic check(string name, logic [NCH-1:0] got, logic [NCH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (gexp_q.size() > 0) begin
      logic [NCH-1:0] ge;
      logic [NCH-1:0] be;
      logic [NCH-1:0] ee;
      ge = gexp_q.pop_front();
      be = '0;
      ee = '0;
      foreach (ent_q[k]) begin
        if (ent_q[k].tg < cyc && cyc < ent_q[k].te) be[ent_q[k].ch] = 1'b1;
        if (ent_q[k].fires && ent_q[k].te == cyc)   ee[ent_q[k].ch] = 1'b1;
      end
      check("grant", bus.grant, ge);
      check("busy", bus.busy, be);
      check("expired", bus.expired, ee);
    end
  end

  initial begin
    bus.start  = '0;
    bus.cancel = '0;
    bus.period = '0;
    for (int t = 0; t < NCYC; t++)
      ce_sched[t] = (t < 500) ? ((t % 20) == 5) : ($urandom_range(0, 5) == 0);
    for (int i = 0; i < NCH; i++) begin
      req_pend[i] = 1'b0;
      req_per[i]  = 0;
    end
    cancel_now = '0;
    ptr_m      = 0;
    rst_now    = 1'b1;
    repeat (4) tick_cycle();
    rst_now = 1'b0;

    // single channel, period 3, strobes at 5, 25, 45, 65 -> expires at 66
    at(10); req(0, 3); tick_cycle();
    // period 0 on ch3: expires next cycle, never busy; leaves ptr at 0
    at(75); req(3, 0); tick_cycle();
    // contention from ptr 0, then pointer-dependent ordering of ch0/ch1
    at(80); req(0, 2); req(1, 3); req(2, 4); req(3, 5); tick_cycle();
    at(84); req(0, 2); req(1, 2); tick_cycle();
    at(86); req(0, 2); tick_cycle();
    at(87); req(0, 3); req(1, 3); tick_cycle();
    // retrigger: period 6 at 200 (deadline 306), restart at 250 with 2 -> 286
    at(200); req(2, 6); tick_cycle();
    at(250); req(2, 2); tick_cycle();
    // cancel on the strobe that would expire ch1 (cnt==1 at 345)
    at(310); req(1, 2); tick_cycle();
    at(345); cancel_now = 4'b0010; tick_cycle(); cancel_now = '0;
    // cancel together with start blocks the grant for that cycle
    at(350); req(1, 1); cancel_now = 4'b0010; tick_cycle(); cancel_now = '0;
    // grant on a strobe cycle with period 1: that strobe is not counted
    at(385); req(0, 1); tick_cycle();
    // reset with two channels busy, then ptr must be back at 0
    at(430); req(0, 4); req(2, 5); tick_cycle();
    at(470); rst_now = 1'b1; tick_cycle(); tick_cycle(); rst_now = 1'b0;
    at(475); req(0, 2); req(3, 2); tick_cycle();

    // random traffic
    at(500);
    while (cyc + 1 < NCYC - 200) begin
      for (int i = 0; i < NCH; i++) begin
        if (!req_pend[i] && $urandom_range(0, 11) == 0) req(i, $urandom_range(0, 6));
        cancel_now[i] = ($urandom_range(0, 39) == 0);
      end
      rst_now = ($urandom_range(0, 599) == 0);
      tick_cycle();
    end
    cancel_now = '0;
    rst_now    = 1'b0;
    at(NCYC - 10);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
